// File: rtl/fetch_stage_unit.sv
// IF stage: owns the PC, runs a single-outstanding imem handshake and drives the IF/ID register.
// One record per cycle with latency-1 memory; stall/flush park a returning word in a hold buffer.
module fetch_stage_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_instr;
  logic        drop;

  logic [31:0] fetch_pc_inc;
  logic [31:0] redirect_tgt;
  logic        resp_live;
  logic        advance;

  assign fetch_pc_inc = fetch_pc + 32'd4;
  assign redirect_tgt = redirect_pc & ~32'd3;
  assign resp_live    = (state == S_WAIT) && imem_rvalid && !drop;
  // A live response goes straight to IF/ID only when nothing holds or kills the stage.
  assign advance      = resp_live && !redirect && !flush && !stall;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    if (!rst) begin
      if (state == S_REQ) begin
        imem_req = !redirect;
      end else if (advance) begin
        imem_req  = 1'b1;
        imem_addr = fetch_pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      drop       <= 1'b0;
      hold_instr <= NOP_INSTR;
      instr      <= NOP_INSTR;
      pc         <= 32'd0;
      pc_plus4   <= 32'd0;
      valid      <= 1'b0;
    end else begin
      if (redirect || flush) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else if (!stall) begin
        if (advance) begin
          instr    <= imem_rdata;
          pc       <= fetch_pc;
          pc_plus4 <= fetch_pc_inc;
          valid    <= 1'b1;
        end else if (state == S_HOLD) begin
          instr    <= hold_instr;
          pc       <= fetch_pc;
          pc_plus4 <= fetch_pc_inc;
          valid    <= 1'b1;
        end else begin
          instr <= NOP_INSTR;
          valid <= 1'b0;
        end
      end

      if (redirect) begin
        fetch_pc <= redirect_tgt;
        case (state)
          S_WAIT: begin
            // Without a response yet, the in-flight word must be swallowed when it lands.
            if (imem_rvalid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end
          default: state <= S_REQ;
        endcase
      end else begin
        case (state)
          S_REQ: state <= S_WAIT;
          S_WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_REQ;
              end else if (stall || flush) begin
                hold_instr <= imem_rdata;
                state      <= S_HOLD;
              end else begin
                fetch_pc <= fetch_pc_inc;
              end
            end
          end
          S_HOLD: begin
            if (!stall && !flush) begin
              fetch_pc <= fetch_pc_inc;
              state    <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_stage_unit.md
Name: fetch_stage_unit

Overview:
Instruction-fetch stage. It is the producing end of the fetch record (instr, pc, pc_plus4) consumed by decode, and the consuming end of the back-channel PC (redirect target) from later stages. It owns the PC register and talks to instruction memory through a single-outstanding request/response handshake. Its output registers form the IF/ID pipeline register, with stall, flush and redirect handling.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall  in  1  hazard unit holds IF/ID; outputs frozen
flush  in  1  replace IF/ID contents with a bubble
redirect  in  1  taken branch/jump from a later stage
redirect_pc  in  32  back-channel target PC
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  32  fetch address, valid when imem_req=1
imem_rvalid  in  1  response valid
imem_rdata  in  32  instruction word
instr  out  32  fetch record: instruction
pc  out  32  fetch record: PC of instr
pc_plus4  out  32  fetch record: pc+4
valid  out  1  fetch record holds a real instruction

Behaviour:
- Reset (async, immediate): state=REQ, fetch_pc=RESET_PC, drop=0, hold buffer empty, instr=NOP_INSTR, pc=0, pc_plus4=0, valid=0, imem_req=0. Imem is reset together with this block, so no stale responses arrive.
- Single outstanding request. Memory latency is at least 1 cycle and unbounded. imem_req/imem_addr are combinational from state and inputs.
- REQ state: imem_req=1, imem_addr=fetch_pc; next state WAIT. If redirect=1, issue nothing: fetch_pc<=redirect_pc, stay REQ.
- WAIT state, no rvalid: IF/ID gets a bubble unless stall=1. Stay WAIT.
- WAIT state, rvalid, drop=1: discard the response, drop<=0, go to REQ.
- WAIT state, rvalid, drop=0, stall=0: load instr=imem_rdata, pc=fetch_pc, pc_plus4=fetch_pc+4, valid=1. fetch_pc<=fetch_pc+4. Back-to-back request in the same cycle: imem_req=1, imem_addr=fetch_pc+4; stay WAIT. This gives 1 instr/cycle with latency-1 memory.
- WAIT state, rvalid, drop=0, stall=1: capture rdata/fetch_pc into the hold buffer; go to HOLD.
- HOLD state: outputs frozen while stall=1. When stall=0, the hold buffer moves to the outputs (valid=1), fetch_pc<=fetch_pc+4, go to REQ.
- stall=1: instr/pc/pc_plus4/valid hold their values. No new request is issued except the initial REQ issue.
- flush=1 (redirect=0): next-cycle outputs are a bubble (instr=NOP_INSTR, valid=0, pc/pc_plus4 hold). An in-flight fetch continues. A response arriving in the same cycle is buffered as if stall=1 and is emitted the following cycle.
- redirect=1: fetch_pc<=redirect_pc with bits[1:0] forced 0. Outputs become a bubble. The hold buffer is discarded.
  - In WAIT without rvalid: drop<=1, stay WAIT.
  - In WAIT with rvalid the same cycle: response discarded, go to REQ.
  - From HOLD: go to REQ.
- Priority: rst > redirect > flush > stall > normal advance.
- Arithmetic: pc_plus4 and fetch_pc increment wrap modulo 2^32.
- valid=0 implies instr=NOP_INSTR.

Test Plan:
1. RESET_PC=0, latency-1 imem returning rdata=0xA000_0000|addr, release rst at cycle 0 -> imem_req every cycle from cycle 0; valid=1 from cycle 2 with pc=0,4,8,… and instr=0xA000_0000,0xA000_0004,…; no gaps.
2. Same stream, stall high for 3 cycles while pc=0x8 -> pc/instr hold 0x8/0xA000_0008; after release the next pc=0xC; no duplicate and no skipped address.
3. Latency-3 imem, redirect to 0x100 one cycle after request to 0x10 -> response for 0x10 dropped (never valid); next valid record pc=0x100, pc_plus4=0x104, instr=0xA000_0100.
4. redirect (target 0x40) in the same cycle as rvalid for 0x20 -> next cycle valid=0, instr=0x13; following request addr=0x40.
5. RESET_PC=0xFFFF_FFFC -> first record pc=0xFFFF_FFFC, pc_plus4=0x0; second record pc=0x0.
6. rst asserted asynchronously mid-WAIT (between clock edges) -> valid=0, instr=0x13, imem_req=0 immediately; after release the first request is to RESET_PC.
